instr_fetch_unit: RTL and testbench

- Front end of the single-cycle RISC-V core; sits directly upstream of the main decoder and consumes its PCSrc decision.
- Owns the PC register and issues word requests to an instruction memory over a req/ready + rvalid handshake.
- Holds the fetched instruction stable for decode/execute until the downstream stage accepts it, then advances the PC.
- Next PC is PC+4 or the branch/jump target, selected by PCSrc.

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, requests one word at a time from
// instruction memory, holds the fetched word for decode until it retires, then
// advances the PC to PC+4 or the taken branch/jump target.
module instr_fetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0   // must be word aligned
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction memory request channel
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  // instruction memory response channel
  input  logic              imem_rvalid,
  input  logic [XLEN-1:0]   imem_rdata,
  // held instruction towards decode
  output logic [XLEN-1:0]   instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  // next-PC selection from the main decoder
  input  logic              pc_src,
  input  logic [XLEN-1:0]   pc_target,
  // PC information for the held instruction
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   pc_plus4_out,
  // status
  output logic [31:0]       instret,
  output logic              fetch_err
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);  // addi x0,x0,0
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [31:0]       instret_q, instret_d;
  logic              fetch_err_q, fetch_err_d;

  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   next_pc;

  // Sequential PC increment wraps modulo 2^XLEN; target only matters on retire.
  always_comb begin
    pc_plus4 = pc_q + PC_STEP;
    next_pc  = pc_src ? pc_target : pc_plus4;
  end

  // Next-state and datapath updates for the fetch sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instret_d   = instret_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        // Address stays on pc_q until memory accepts it.
        if (imem_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        // Response data is only ever taken here; strays elsewhere are dropped.
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Retire handshake: pc_src/pc_target are only meaningful on this edge.
        if (instr_ready) begin
          pc_d      = next_pc;
          instret_d = instret_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            // Keep the offending PC visible for debug and stop fetching.
            fetch_err_d = 1'b1;
            state_d     = ERR;
          end else begin
            state_d = REQ;
          end
        end
      end

      ERR: begin
        fetch_err_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset overriding every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      instret_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instret_q   <= instret_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    imem_req     = (state_q == REQ);
    imem_addr    = pc_q;
    instr_valid  = (state_q == HOLD);
    instr_out    = instr_q;
    pc_out       = pc_q;
    pc_plus4_out = pc_plus4;
    instret      = instret_q;
    fetch_err    = fetch_err_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/retire traffic compared against a transaction-level model of the PC,
// retired count, held instruction and error flag.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_n_w;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        pc_src;
  logic [31:0] pc_target;

  // main instance (RESET_PC = 0)
  logic        m_req, m_valid, m_err;
  logic [31:0] m_addr, m_instr_o, m_pc_o, m_pc4_o, m_instret_o;
  // wrap instance (RESET_PC = 0xFFFF_FFFC)
  logic        w_req, w_valid, w_err;
  logic [31:0] w_addr, w_instr_o, w_pc_o, w_pc4_o, w_instret_o;

  // observed signals of the instance under test
  logic        sel;
  logic        o_req, o_valid, o_err;
  logic [31:0] o_addr, o_instr, o_pc, o_pc4, o_instret;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] mdl_pc;
  logic [31:0] mdl_instr;
  logic [31:0] mdl_instret;
  logic        mdl_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(m_req), .imem_addr(m_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(m_instr_o), .instr_valid(m_valid), .instr_ready(instr_ready),
    .pc_src(pc_src), .pc_target(pc_target),
    .pc_out(m_pc_o), .pc_plus4_out(m_pc4_o),
    .instret(m_instret_o), .fetch_err(m_err)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n_w),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(w_instr_o), .instr_valid(w_valid), .instr_ready(instr_ready),
    .pc_src(pc_src), .pc_target(pc_target),
    .pc_out(w_pc_o), .pc_plus4_out(w_pc4_o),
    .instret(w_instret_o), .fetch_err(w_err)
  );

  assign o_req     = sel ? w_req       : m_req;
  assign o_valid   = sel ? w_valid     : m_valid;
  assign o_err     = sel ? w_err       : m_err;
  assign o_addr    = sel ? w_addr      : m_addr;
  assign o_instr   = sel ? w_instr_o   : m_instr_o;
  assign o_pc      = sel ? w_pc_o      : m_pc_o;
  assign o_pc4     = sel ? w_pc4_o     : m_pc4_o;
  assign o_instret = sel ? w_instret_o : m_instret_o;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst_n_w = v;
    else     rst_n   = v;
  endtask

  // Hold reset for some cycles, check reset state, release and check the first request.
  task automatic do_reset(input int cycles, input logic [31:0] rpc);
    set_rst(1'b0);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = '0;
    for (int i = 0; i < cycles; i++) tick();
    mdl_pc      = rpc;
    mdl_instr   = 32'h0000_0013;
    mdl_instret = '0;
    mdl_err     = 1'b0;
    chk("rst_req",     {31'b0, o_req},   32'd0);
    chk("rst_valid",   {31'b0, o_valid}, 32'd0);
    chk("rst_err",     {31'b0, o_err},   32'd0);
    chk("rst_instret", o_instret,        32'd0);
    chk("rst_pc",      o_pc,             rpc);
    chk("rst_instr",   o_instr,          32'h0000_0013);
    set_rst(1'b1);
    tick();
    chk("rel_req",  {31'b0, o_req}, 32'd1);
    chk("rel_addr", o_addr,         rpc);
    $display("reset  pc=%h", rpc);
  endtask

  // One complete fetch/retire transaction, starting with the DUT in REQ.
  task automatic fetch_one(input int rdly, input int vdly, input int hdly,
                           input logic src, input logic [31:0] tgt);
    logic [31:0] word;
    logic [31:0] nxt;
    word = mem_word(mdl_pc);
    // request phase with memory stalling; stray rvalid must be ignored
    for (int i = 0; i < rdly; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = 32'hDEAD_BEEF;
      chk("req_stall_req",   {31'b0, o_req},   32'd1);
      chk("req_stall_addr",  o_addr,           mdl_pc);
      chk("req_stall_valid", {31'b0, o_valid}, 32'd0);
      chk("req_stall_instr", o_instr,          mdl_instr);
      tick();
    end
    chk("req_req",   {31'b0, o_req}, 32'd1);
    chk("req_addr",  o_addr,         mdl_pc);
    chk("req_instr", o_instr,        mdl_instr);
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    tick();
    // waiting for data; stray ready must be ignored
    for (int i = 0; i < vdly; i++) begin
      imem_ready  = 1'($urandom_range(0, 1));
      imem_rvalid = 1'b0;
      chk("wait_req",   {31'b0, o_req},   32'd0);
      chk("wait_valid", {31'b0, o_valid}, 32'd0);
      tick();
    end
    chk("wait_req", {31'b0, o_req}, 32'd0);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    mdl_instr = word;
    // hold phase with downstream backpressure and noise on unrelated inputs
    for (int i = 0; i <= hdly; i++) begin
      if (i < hdly) begin
        instr_ready = 1'b0;
        pc_src      = 1'($urandom_range(0, 1));
        pc_target   = $urandom;
        imem_ready  = 1'($urandom_range(0, 1));
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
      end else begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
      end
      chk("hold_valid",   {31'b0, o_valid}, 32'd1);
      chk("hold_req",     {31'b0, o_req},   32'd0);
      chk("hold_instr",   o_instr,          mdl_instr);
      chk("hold_pc",      o_pc,             mdl_pc);
      chk("hold_pc4",     o_pc4,            mdl_pc + 32'd4);
      chk("hold_instret", o_instret,        mdl_instret);
      chk("hold_err",     {31'b0, o_err},   32'd0);
      if (i < hdly) tick();
    end
    // retire handshake
    instr_ready = 1'b1;
    pc_src      = src;
    pc_target   = tgt;
    tick();
    instr_ready = 1'b0;
    pc_src      = 1'($urandom_range(0, 1));
    pc_target   = $urandom;
    nxt = src ? tgt : mdl_pc + 32'd4;
    $display("retire pc=%h instr=%h src=%0d next=%h", mdl_pc, mdl_instr, src, nxt);
    mdl_pc      = nxt;
    mdl_instret = mdl_instret + 32'd1;
    if (nxt[1:0] != 2'b00) mdl_err = 1'b1;
    chk("post_err",     {31'b0, o_err},   {31'b0, mdl_err});
    chk("post_instret", o_instret,        mdl_instret);
    chk("post_valid",   {31'b0, o_valid}, 32'd0);
    chk("post_pc",      o_pc,             mdl_pc);
    chk("post_req",     {31'b0, o_req},   {31'b0, ~mdl_err});
  endtask

  initial begin
    sel         = 1'b0;
    rst_n       = 1'b0;
    rst_n_w     = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = '0;

    // reset then sequential fetch: addresses 0x0, 0x4, 0x8; valid 3 edges after release
    do_reset(2, 32'h0);
    fetch_one(0, 0, 0, 1'b0, 32'h0);
    fetch_one(0, 0, 0, 1'b0, 32'h0);
    fetch_one(0, 0, 0, 1'b0, 32'h0);
    chk("seq_instret3", o_instret, 32'd3);
    chk("seq_addr_c",   o_addr,    32'h0000_000C);

    // reach pc=0x10, then branch taken to 0x40
    fetch_one(0, 0, 0, 1'b0, 32'h0);
    chk("br_pc10", o_addr, 32'h0000_0010);
    fetch_one(0, 0, 0, 1'b1, 32'h0000_0040);
    chk("br_addr40", o_addr, 32'h0000_0040);

    // backpressure on both sides
    fetch_one(4, 0, 5, 1'b0, 32'h0);

    // randomized traffic with aligned targets
    for (int n = 0; n < 25; n++) begin
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
    end

    // misaligned target: sticky error, no further requests
    fetch_one(0, 1, 1, 1'b1, 32'h0000_0022);
    chk("mis_pc", o_pc, 32'h0000_0022);
    for (int i = 0; i < 4; i++) begin
      imem_ready  = 1'($urandom_range(0, 1));
      imem_rvalid = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      tick();
      chk("err_sticky", {31'b0, o_err},   32'd1);
      chk("err_req",    {31'b0, o_req},   32'd0);
      chk("err_valid",  {31'b0, o_valid}, 32'd0);
    end
    instr_ready = 1'b0;

    // reset during WAIT, late rvalid after release is dropped
    do_reset(2, 32'h0);
    imem_ready = 1'b1;
    tick();
    chk("rw_in_wait", {31'b0, o_req}, 32'd0);
    imem_ready = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk("rw_valid", {31'b0, o_valid}, 32'd0);
    chk("rw_req",   {31'b0, o_req},   32'd1);
    chk("rw_addr",  o_addr,           32'h0);
    chk("rw_instr", o_instr,          32'h0000_0013);
    tick();
    chk("rw_stray_instr", o_instr,          32'h0000_0013);
    chk("rw_stray_valid", {31'b0, o_valid}, 32'd0);
    imem_rvalid = 1'b0;
    fetch_one(0, 0, 0, 1'b0, 32'h0);

    // PC wrap on the second instance
    rst_n = 1'b0;
    sel   = 1'b1;
    do_reset(2, 32'hFFFF_FFFC);
    fetch_one(1, 0, 0, 1'b0, 32'h0);
    chk("wrap_addr", o_addr,         32'h0);
    chk("wrap_err",  {31'b0, o_err}, 32'd0);
    fetch_one(1, 1, 1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
